cache_axi_arbiter: RTL and testbench

- Sits directly downstream of the instruction cache and the data cache.
- Takes single-word miss/uncached requests from both caches and serialises them onto one AXI4 master port, at most one transaction outstanding.
- Returns read data with a one-cycle done pulse (`*_dok`) per requester.
- Instruction-cache side matches the existing `inst_cache_req` / `inst_cache_rdata` / `inst_cache_dok` handshake.

---
 rtl/cache_axi_arbiter_pkg.sv | 23 ++
 rtl/cache_axi_arbiter_grant.sv | 32 +++
 rtl/cache_axi_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_cache_axi_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_axi_arbiter_pkg.sv
// Shared types and constants for the cache-to-AXI arbiter.
// Optional round-robin tie breaking is enabled with ARB_ROUND_ROBIN_EN.
package cache_axi_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'd2;
    localparam logic       OWN_INST   = 1'b0;
    localparam logic       OWN_DATA   = 1'b1;

    function automatic logic [2:0] to_axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/cache_axi_arbiter_grant.sv
// Grant select between icache and dcache requests (module cache_arb_grant).
// ARB_ROUND_ROBIN_EN swaps fixed data priority for alternating tie breaks.
module cache_arb_grant
    import cache_axi_arbiter_pkg::*;
(
    input  logic inst_req,
    input  logic data_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_grant,
`endif
    output logic grant_valid,
    output logic grant_owner
);

    // Pick a winner among the pending requests
    always_comb begin
        grant_valid = inst_req | data_req;
        grant_owner = OWN_INST;
        if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_owner = (last_grant == OWN_DATA) ? OWN_INST : OWN_DATA;
`else
            grant_owner = OWN_DATA;
`endif
        end else if (data_req) begin
            grant_owner = OWN_DATA;
        end else begin
            grant_owner = OWN_INST;
        end
    end

endmodule

// File: rtl/cache_axi_arbiter.sv
// Serialises single-word icache/dcache accesses onto one AXI4 master, one at a time.
// Optional macro ARB_ROUND_ROBIN_EN adds a last_grant register for fair tie breaks.
module cache_axi_arbiter
    import cache_axi_arbiter_pkg::*;
#(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_cache_req,
    input  logic [31:0] inst_cache_addr,
    output logic [31:0] inst_cache_rdata,
    output logic        inst_cache_dok,
    input  logic        data_cache_req,
    input  logic        data_cache_wr,
    input  logic [1:0]  data_cache_size,
    input  logic [3:0]  data_cache_wstrb,
    input  logic [31:0] data_cache_addr,
    input  logic [31:0] data_cache_wdata,
    output logic [31:0] data_cache_rdata,
    output logic        data_cache_dok,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    state_t      state_r, state_s;
    logic        owner_r;
    logic [31:0] addr_r, wdata_r, inst_rdata_r, data_rdata_r;
    logic [2:0]  size_r;
    logic [3:0]  wstrb_r;
    logic        aw_done_r, w_done_r;
    logic        grant_valid_s, grant_owner_s;
    logic        unused_s;

    // Error responses and rlast never change completion
    assign unused_s = ^{rresp, rlast, bresp};

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_r;

    // Remember who was granted last for the next tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r <= OWN_INST;
        end else if (state_r == ST_IDLE && grant_valid_s) begin
            last_grant_r <= grant_owner_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    cache_arb_grant u_grant (
        .inst_req    (inst_cache_req),
        .data_req    (data_cache_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant  (last_grant_r),
`endif
        .grant_valid (grant_valid_s),
        .grant_owner (grant_owner_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; AW and W handshakes may complete in either order
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    state_s = (grant_owner_s == OWN_DATA && data_cache_wr) ? ST_AW_W : ST_AR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_AR:   state_s = arready ? ST_R : ST_AR;
            ST_R:    state_s = rvalid ? ST_DONE : ST_R;
            ST_AW_W: state_s = ((aw_done_r || awready) && (w_done_r || wready)) ? ST_B : ST_AW_W;
            ST_B:    state_s = bvalid ? ST_DONE : ST_B;
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Request capture, handshake tracking and read-data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_r      <= OWN_INST;
            addr_r       <= 32'd0;
            size_r       <= 3'd0;
            wstrb_r      <= 4'd0;
            wdata_r      <= 32'd0;
            inst_rdata_r <= 32'd0;
            data_rdata_r <= 32'd0;
            aw_done_r    <= 1'b0;
            w_done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    aw_done_r <= 1'b0;
                    w_done_r  <= 1'b0;
                    if (grant_valid_s && grant_owner_s == OWN_DATA) begin
                        owner_r <= OWN_DATA;
                        addr_r  <= data_cache_addr;
                        size_r  <= to_axi_size(data_cache_size);
                        wstrb_r <= data_cache_wstrb;
                        wdata_r <= data_cache_wdata;
                    end else if (grant_valid_s) begin
                        owner_r <= OWN_INST;
                        addr_r  <= inst_cache_addr;
                        size_r  <= SIZE_WORD;
                    end
                end
                ST_R: begin
                    if (rvalid && owner_r == OWN_DATA) begin
                        data_rdata_r <= rdata;
                    end else if (rvalid) begin
                        inst_rdata_r <= rdata;
                    end
                end
                ST_AW_W: begin
                    if (awvalid && awready) aw_done_r <= 1'b1;
                    if (wvalid && wready)   w_done_r  <= 1'b1;
                end
                default: begin
                    aw_done_r <= aw_done_r;
                end
            endcase
        end
    end

    // Handshake and done outputs decoded from the state register
    always_comb begin
        arvalid        = 1'b0;
        rready         = 1'b0;
        awvalid        = 1'b0;
        wvalid         = 1'b0;
        bready         = 1'b0;
        inst_cache_dok = 1'b0;
        data_cache_dok = 1'b0;
        case (state_r)
            ST_AR:   arvalid = 1'b1;
            ST_R:    rready  = 1'b1;
            ST_AW_W: begin
                awvalid = ~aw_done_r;
                wvalid  = ~w_done_r;
            end
            ST_B:    bready  = 1'b1;
            ST_DONE: begin
                inst_cache_dok = (owner_r == OWN_INST);
                data_cache_dok = (owner_r == OWN_DATA);
            end
            default: arvalid = 1'b0;
        endcase
    end

    assign inst_cache_rdata = inst_rdata_r;
    assign data_cache_rdata = data_rdata_r;
    assign arid    = (owner_r == OWN_DATA) ? DATA_ID : INST_ID;
    assign araddr  = addr_r;
    assign arsize  = size_r;
    assign arlen   = 8'd0;
    assign arburst = BURST_INCR;
    assign arlock  = 1'b0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awid    = DATA_ID;
    assign awaddr  = addr_r;
    assign awsize  = size_r;
    assign awlen   = 8'd0;
    assign awburst = BURST_INCR;
    assign awlock  = 1'b0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = DATA_ID;
    assign wdata   = wdata_r;
    assign wstrb   = wstrb_r;
    assign wlast   = 1'b1;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter with a transaction-level model and AXI slave.
module tb_cache_axi_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_cache_req = 1'b0;
    logic [31:0] inst_cache_addr = 32'd0;
    logic [31:0] inst_cache_rdata;
    logic        inst_cache_dok;
    logic        data_cache_req = 1'b0;
    logic        data_cache_wr = 1'b0;
    logic [1:0]  data_cache_size = 2'd0;
    logic [3:0]  data_cache_wstrb = 4'd0;
    logic [31:0] data_cache_addr = 32'd0;
    logic [31:0] data_cache_wdata = 32'd0;
    logic [31:0] data_cache_rdata;
    logic        data_cache_dok;
    logic [3:0]  arid, awid, wid, arcache, awcache, wstrb;
    logic [31:0] araddr, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst;
    logic        arlock, awlock, arvalid, rready, awvalid, wvalid, wlast, bready;
    logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b0, awready = 1'b0;
    logic        wready = 1'b0, bvalid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic [1:0]  rresp = 2'd0, bresp = 2'd0;

    always #5 clk = ~clk;

    cache_axi_arbiter dut (
        .clk(clk), .reset(reset),
        .inst_cache_req(inst_cache_req), .inst_cache_addr(inst_cache_addr),
        .inst_cache_rdata(inst_cache_rdata), .inst_cache_dok(inst_cache_dok),
        .data_cache_req(data_cache_req), .data_cache_wr(data_cache_wr),
        .data_cache_size(data_cache_size), .data_cache_wstrb(data_cache_wstrb),
        .data_cache_addr(data_cache_addr), .data_cache_wdata(data_cache_wdata),
        .data_cache_rdata(data_cache_rdata), .data_cache_dok(data_cache_dok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid),
        .bready(bready)
    );

    typedef struct {
        logic        owner;   // 0 = inst, 1 = data
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          req_cyc;
    } txn_t;

    txn_t exp_q[$];
    logic dok_log[$];

    int checks = 0, passes = 0, cyc = 0;
    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [31:0] r_data_val = 32'd0;
    logic [1:0]  r_resp_val = 2'd0;

    logic        fin_pending = 1'b0, fin_owner = 1'b0, fin_wr = 1'b0;
    logic [31:0] fin_data = 32'd0;
    logic        prev_reset = 1'b1;
    logic        prev_arvalid = 1'b0, prev_arready = 1'b0, prev_rready = 1'b0, prev_rvalid = 1'b0;
    logic        prev_awvalid = 1'b0, prev_awready = 1'b0, prev_wvalid = 1'b0, prev_wready = 1'b0;
    logic [31:0] prev_araddr = 32'd0;
    int          inst_dok_cnt = 0, data_dok_cnt = 0, last_latency = 0;
    logic [31:0] last_araddr = 32'd0;
    logic [3:0]  last_arid = 4'd0, last_awid = 4'd0;
    logic [2:0]  last_arsize = 3'd0, last_awsize = 3'd0;
    logic        aw_only_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: queue expected transactions in the order the arbiter must serve them
    task automatic issue(input bit inst_v, input logic [31:0] iaddr,
                         input bit data_v, input logic wr, input logic [1:0] size,
                         input logic [3:0] strb, input logic [31:0] daddr, input logic [31:0] wd);
        txn_t t;
        if (data_v) begin
            t.owner = 1'b1; t.wr = wr; t.addr = daddr; t.size = {1'b0, size};
            t.wstrb = strb; t.wdata = wd; t.req_cyc = cyc;
            exp_q.push_back(t);
            data_cache_req = 1'b1; data_cache_wr = wr; data_cache_size = size;
            data_cache_wstrb = strb; data_cache_addr = daddr; data_cache_wdata = wd;
        end
        if (inst_v) begin
            t.owner = 1'b0; t.wr = 1'b0; t.addr = iaddr; t.size = 3'd2;
            t.wstrb = 4'd0; t.wdata = 32'd0; t.req_cyc = cyc;
            exp_q.push_back(t);
            inst_cache_req = 1'b1; inst_cache_addr = iaddr;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || inst_cache_req || data_cache_req) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_done_in_budget", 32'(n < 300), 32'd1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    // Compare process, AXI slave and requester drop, all on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (prev_reset) begin
                check("rst_arvalid", 32'(arvalid), 32'd0);
                check("rst_rready", 32'(rready), 32'd0);
                check("rst_awvalid", 32'(awvalid), 32'd0);
                check("rst_wvalid", 32'(wvalid), 32'd0);
                check("rst_bready", 32'(bready), 32'd0);
                check("rst_doks", {30'd0, inst_cache_dok, data_cache_dok}, 32'd0);
                exp_q.delete();
            end else begin
                check("inst_dok", 32'(inst_cache_dok), 32'(fin_pending && !fin_owner));
                check("data_dok", 32'(data_cache_dok), 32'(fin_pending && fin_owner));
                if (fin_pending) begin
                    if (!fin_owner) check("inst_rdata", inst_cache_rdata, fin_data);
                    else if (!fin_wr) check("data_rdata", data_cache_rdata, fin_data);
                    dok_log.push_back(fin_owner);
                    last_latency = cyc - exp_q[0].req_cyc;
                    void'(exp_q.pop_front());
                end
                if (inst_cache_dok) inst_dok_cnt++;
                if (data_cache_dok) data_dok_cnt++;
                if (prev_arvalid && !prev_arready) begin
                    check("ar_valid_hold", 32'(arvalid), 32'd1);
                    check("ar_addr_hold", araddr, prev_araddr);
                end
                if (prev_rready && !prev_rvalid) check("r_ready_hold", 32'(rready), 32'd1);
                if (prev_wvalid) check("w_valid_after", 32'(wvalid), 32'(!prev_wready));
                if (prev_awvalid) check("aw_valid_after", 32'(awvalid), 32'(!prev_awready));
                if (arvalid) begin
                    check("ar_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        check("ar_is_read", 32'(exp_q[0].wr), 32'd0);
                        check("araddr", araddr, exp_q[0].addr);
                        check("arid", 32'(arid), exp_q[0].owner ? 32'd1 : 32'd0);
                        check("arsize", 32'(arsize), 32'(exp_q[0].size));
                    end
                    last_araddr = araddr; last_arid = arid; last_arsize = arsize;
                end
                if (awvalid || wvalid) begin
                    check("aw_w_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        check("aw_w_is_write", 32'(exp_q[0].wr), 32'd1);
                        if (awvalid) begin
                            check("awaddr", awaddr, exp_q[0].addr);
                            check("awsize", 32'(awsize), 32'(exp_q[0].size));
                            check("awid", 32'(awid), 32'd1);
                            last_awid = awid; last_awsize = awsize;
                        end
                        if (wvalid) begin
                            check("wdata", wdata, exp_q[0].wdata);
                            check("wstrb", 32'(wstrb), 32'(exp_q[0].wstrb));
                            check("wlast", 32'(wlast), 32'd1);
                        end
                    end
                    if (awvalid && !wvalid) aw_only_seen = 1'b1;
                end
            end
            // slave: readies/valids for the coming rising edge
            if (reset) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end else begin
                if (arvalid) begin arready = (ar_cnt >= ar_delay); ar_cnt++; end
                else begin arready = 0; ar_cnt = 0; end
                if (rready) begin rvalid = (r_cnt >= r_delay); r_cnt++; end
                else begin rvalid = 0; r_cnt = 0; end
                if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
                else begin awready = 0; aw_cnt = 0; end
                if (wvalid) begin wready = (w_cnt >= w_delay); w_cnt++; end
                else begin wready = 0; w_cnt = 0; end
                if (bready) begin bvalid = (b_cnt >= b_delay); b_cnt++; end
                else begin bvalid = 0; b_cnt = 0; end
            end
            rdata = r_data_val; rresp = r_resp_val; rlast = 1'b1; bresp = 2'b00;
            // a completing handshake at the next edge means dok in the following cycle
            fin_pending = !reset && exp_q.size() != 0 && ((rvalid && rready) || (bvalid && bready));
            fin_owner = (exp_q.size() != 0) ? exp_q[0].owner : 1'b0;
            fin_wr    = (exp_q.size() != 0) ? exp_q[0].wr : 1'b0;
            fin_data  = rdata;
            prev_reset = reset;
            prev_arvalid = arvalid; prev_arready = arready; prev_araddr = araddr;
            prev_rready = rready; prev_rvalid = rvalid;
            prev_awvalid = awvalid; prev_awready = awready;
            prev_wvalid = wvalid; prev_wready = wready;
            if (inst_cache_dok) inst_cache_req = 1'b0;
            if (data_cache_dok) data_cache_req = 1'b0;
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Inst read, zero-wait slave
        @(posedge clk); #2;
        r_data_val = 32'h2402_0001;
        issue(1, 32'hBFC0_0000, 0, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0);
        wait_done();
        check("t1_latency", 32'(last_latency), 32'd3);
        check("t1_rdata", inst_cache_rdata, 32'h2402_0001);
        check("t1_araddr", last_araddr, 32'hBFC0_0000);
        check("t1_arid", 32'(last_arid), 32'd0);
        check("t1_arsize", 32'(last_arsize), 32'd2);
        check("t1_inst_dok_count", 32'(inst_dok_cnt), 32'd1);

        // Data byte write, W accepted two cycles before AW
        inst_dok_cnt = 0; data_dok_cnt = 0; aw_only_seen = 1'b0;
        aw_delay = 2; w_delay = 0; b_delay = 2;
        issue(0, 32'd0, 1, 1'b1, 2'd0, 4'b1000, 32'h8000_0013, 32'hAB00_0000);
        wait_done();
        check("t2_awsize", 32'(last_awsize), 32'd0);
        check("t2_awid", 32'(last_awid), 32'd1);
        check("t2_aw_held_after_w", 32'(aw_only_seen), 32'd1);
        check("t2_data_dok_count", 32'(data_dok_cnt), 32'd1);
        check("t2_inst_dok_count", 32'(inst_dok_cnt), 32'd0);

        // Simultaneous reads: data first, then inst
        aw_delay = 0; b_delay = 0; dok_log.delete();
        r_data_val = 32'h1111_2222;
        issue(1, 32'hBFC0_0004, 1, 1'b0, 2'd2, 4'hF, 32'h8000_1000, 32'd0);
        wait_done();
        check("t3_dok_count", 32'(dok_log.size()), 32'd2);
        if (dok_log.size() == 2) begin
            check("t3_first_is_data", 32'(dok_log[0]), 32'd1);
            check("t3_second_is_inst", 32'(dok_log[1]), 32'd0);
        end

        // AR stalled 5 cycles, R stalled 4 cycles
        ar_delay = 5; r_delay = 4;
        r_data_val = 32'h0000_0ABC;
        issue(1, 32'hBFC0_0100, 0, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0);
        wait_done();
        check("t4_latency", 32'(last_latency), 32'd12);
        check("t4_rdata", inst_cache_rdata, 32'h0000_0ABC);

        // Reset while waiting in R abandons the transfer
        ar_delay = 0; r_delay = 20; inst_dok_cnt = 0;
        issue(1, 32'hBFC0_0200, 0, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0);
        n = 0;
        while (!rready && n < 50) begin @(negedge clk); n++; end
        check("t5_reached_r", 32'(rready), 32'd1);
        @(posedge clk); #2;
        reset = 1'b1; inst_cache_req = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        repeat (25) @(posedge clk);
        #2;
        check("t5_no_dok", 32'(inst_dok_cnt), 32'd0);
        check("t5_rdata_cleared", inst_cache_rdata, 32'd0);

        // SLVERR read still completes with the returned data
        r_delay = 0; r_resp_val = 2'b10; data_dok_cnt = 0;
        r_data_val = 32'hDEAD_BEEF;
        issue(0, 32'd0, 1, 1'b0, 2'd2, 4'hF, 32'h8000_0040, 32'd0);
        wait_done();
        check("t6_rdata", data_cache_rdata, 32'hDEAD_BEEF);
        check("t6_data_dok_count", 32'(data_dok_cnt), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
